knapsack_instance_gen: RTL and testbench

Hardware problem-instance writer for the genetic_algorithm knapsack core. It drives the core's item_values, item_weights and capacity inputs. On start it regenerates a reproducible instance from a 31-bit LCG (seed SEED), the same sequence the simulation model uses. It also computes capacity as CAP_PERCENT of the total item weight. It sits between the system controller and the GA, and the GA is started only after done.

---
 rtl/knapsack_instance_gen.sv | 221 ++++++++++++++++++++++
 tb/tb_knapsack_instance_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/knapsack_instance_gen.sv
// knapsack_instance_gen
//
// Writes a reproducible knapsack problem instance for the genetic_algorithm
// core. On an accepted start the 31-bit LCG is reloaded with SEED and, for
// every item in ascending order, one LCG step plus a 31-cycle restoring
// remainder produce the value, then the same again produces the weight.
// Each item therefore takes exactly 64 cycles. After the last item the
// capacity is computed as floor(total_weight * CAP_PERCENT / 100) with a
// 1-cycle multiply and a 24-cycle restoring divide.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   start         generation request, sampled only in IDLE or DONE
//   busy          high while generating
//   done          level; instance and capacity are valid
//   item_values   byte i = value of item i
//   item_weights  byte i = weight of item i
//   total_weight  sum of all weights
//   capacity      floor(total_weight * CAP_PERCENT / 100)
//   fsm_state     current FSM state (debug visibility)
//
// Handshake: start is a request with no ready; it is accepted on any clock
// edge where the FSM is in IDLE or DONE and ignored otherwise. done is a
// level that stays high until the next accepted start clears it on that
// same edge; busy is high from the accept edge until the edge that sets done.

module knapsack_instance_gen #(
  parameter int CHROMOSOME_LENGTH = 128,
  parameter int SEED              = 42,
  parameter int VALUE_MIN         = 10,
  parameter int VALUE_SPAN        = 91,
  parameter int WEIGHT_MIN        = 5,
  parameter int WEIGHT_SPAN       = 46,
  parameter int CAP_PERCENT       = 40
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic [CHROMOSOME_LENGTH*8-1:0] item_values,
  output logic [CHROMOSOME_LENGTH*8-1:0] item_weights,
  output logic [15:0]                    total_weight,
  output logic [15:0]                    capacity,
  output logic [2:0]                     fsm_state
);

  // Index must be able to hold CHROMOSOME_LENGTH after the final increment.
  localparam int IDX_W = $clog2(CHROMOSOME_LENGTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHROMOSOME_LENGTH - 1);

  localparam logic [4:0] MOD_LAST = 5'd30;  // 31 dividend bits
  localparam logic [4:0] DIV_LAST = 5'd23;  // 24 dividend bits

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LCG_V   = 3'd1,
    S_MOD_V   = 3'd2,
    S_LCG_W   = 3'd3,
    S_MOD_W   = 3'd4,
    S_CAP_MUL = 3'd5,
    S_CAP_DIV = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t           state;
  logic [30:0]      lcg;
  logic [30:0]      mod_sh;   // dividend shifted out MSB first
  logic [7:0]       rem;      // running remainder, always < span
  logic [4:0]       cnt;
  logic [IDX_W-1:0] index;
  logic [23:0]      prod;     // dividend, becomes the quotient bit by bit
  logic [7:0]       div_rem;  // running remainder, always < 100

  assign fsm_state = state;

  // The 31-bit result width gives the & 0x7FFFFFFF for free.
  logic [30:0] lcg_next;
  assign lcg_next = lcg * 31'd1103515245 + 31'd12345;

  // One restoring-remainder step on the LCG sample.
  logic [8:0] mod_span;
  logic [8:0] rem_trial;
  logic [7:0] rem_new;
  logic [7:0] item_base;
  logic [7:0] item_byte;

  always_comb begin
    mod_span  = (state == S_MOD_W) ? 9'(WEIGHT_SPAN) : 9'(VALUE_SPAN);
    item_base = (state == S_MOD_W) ? 8'(WEIGHT_MIN) : 8'(VALUE_MIN);
    rem_trial = {rem, mod_sh[30]};
    rem_new   = rem_trial[7:0];
    if (rem_trial >= mod_span) begin
      rem_new = 8'(rem_trial - mod_span);
    end
    item_byte = item_base + rem_new;
  end

  // One restoring-divide step by 100 for the capacity.
  logic [8:0]  div_trial;
  logic        q_bit;
  logic [7:0]  div_rem_new;
  logic [23:0] prod_new;

  always_comb begin
    div_trial   = {div_rem, prod[23]};
    q_bit       = (div_trial >= 9'd100);
    div_rem_new = div_trial[7:0];
    if (q_bit) begin
      div_rem_new = 8'(div_trial - 9'd100);
    end
    prod_new = {prod[22:0], q_bit};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      item_values  <= '0;
      item_weights <= '0;
      total_weight <= '0;
      capacity     <= '0;
      lcg          <= 31'(SEED);
      mod_sh       <= '0;
      rem          <= '0;
      cnt          <= '0;
      index        <= '0;
      prod         <= '0;
      div_rem      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // DONE counts as idle for acceptance; item bytes and capacity
          // are kept until overwritten by the new run.
          if (start) begin
            lcg          <= 31'(SEED);
            index        <= '0;
            total_weight <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            state        <= S_LCG_V;
          end
        end

        S_LCG_V: begin
          lcg    <= lcg_next;
          mod_sh <= lcg_next;
          rem    <= '0;
          cnt    <= '0;
          state  <= S_MOD_V;
        end

        S_MOD_V: begin
          rem    <= rem_new;
          mod_sh <= {mod_sh[29:0], 1'b0};
          cnt    <= cnt + 5'd1;
          if (cnt == MOD_LAST) begin
            for (int i = 0; i < CHROMOSOME_LENGTH; i++) begin
              if (index == IDX_W'(i)) begin
                item_values[i*8 +: 8] <= item_byte;
              end
            end
            state <= S_LCG_W;
          end
        end

        S_LCG_W: begin
          lcg    <= lcg_next;
          mod_sh <= lcg_next;
          rem    <= '0;
          cnt    <= '0;
          state  <= S_MOD_W;
        end

        S_MOD_W: begin
          rem    <= rem_new;
          mod_sh <= {mod_sh[29:0], 1'b0};
          cnt    <= cnt + 5'd1;
          if (cnt == MOD_LAST) begin
            for (int i = 0; i < CHROMOSOME_LENGTH; i++) begin
              if (index == IDX_W'(i)) begin
                item_weights[i*8 +: 8] <= item_byte;
              end
            end
            total_weight <= total_weight + {8'd0, item_byte};
            index        <= index + 1'b1;
            state        <= (index == LAST_IDX) ? S_CAP_MUL : S_LCG_V;
          end
        end

        S_CAP_MUL: begin
          prod    <= 24'(total_weight) * 24'(CAP_PERCENT);
          div_rem <= '0;
          cnt     <= '0;
          state   <= S_CAP_DIV;
        end

        S_CAP_DIV: begin
          prod    <= prod_new;
          div_rem <= div_rem_new;
          cnt     <= cnt + 5'd1;
          if (cnt == DIV_LAST) begin
            capacity <= prod_new[15:0];
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knapsack_instance_gen.sv
// tb_knapsack_instance_gen
//
// Directed bench for knapsack_instance_gen. Instance "dut" uses the default
// parameters (128 items, 40 %); instance "dut1" uses one item and 100 %.
// Expected item bytes come from a behavioural LCG model using the %
// operator; first-item bytes, latencies and the one-item results are
// hand-computed constants.

module tb_knapsack_instance_gen;

  localparam int L  = 128;
  localparam int NB = L * 8;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst1;
  logic start, start1;

  logic          busy, done;
  logic [NB-1:0] item_values, item_weights;
  logic [15:0]   total_weight, capacity;
  logic [2:0]    fsm_state;

  logic          busy1, done1;
  logic [7:0]    item_values1, item_weights1;
  logic [15:0]   total_weight1, capacity1;
  logic [2:0]    fsm_state1;

  knapsack_instance_gen dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .item_values  (item_values),
    .item_weights (item_weights),
    .total_weight (total_weight),
    .capacity     (capacity),
    .fsm_state    (fsm_state)
  );

  knapsack_instance_gen #(
    .CHROMOSOME_LENGTH (1),
    .CAP_PERCENT       (100)
  ) dut1 (
    .clk          (clk),
    .rst          (rst1),
    .start        (start1),
    .busy         (busy1),
    .done         (done1),
    .item_values  (item_values1),
    .item_weights (item_weights1),
    .total_weight (total_weight1),
    .capacity     (capacity1),
    .fsm_state    (fsm_state1)
  );

  // Scoreboard
  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  int         exp_total;
  int         exp_cap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [30:0] lcg_model(input logic [30:0] x);
    logic [63:0] t;
    t = 64'(x) * 64'd1103515245 + 64'd12345;
    return t[30:0];
  endfunction

  // Fills exp_q with all values then all weights for the default instance.
  task automatic load_model();
    logic [30:0] s;
    int v, w;
    exp_q.delete();
    exp_total = 0;
    s = 31'd42;
    for (int i = 0; i < L; i++) begin
      s = lcg_model(s);
      v = 10 + int'(s % 31'd91);
      s = lcg_model(s);
      w = 5 + int'(s % 31'd46);
      exp_q.push_back(8'(v));
      exp_total += w;
    end
    s = 31'd42;
    for (int i = 0; i < L; i++) begin
      s = lcg_model(s);
      s = lcg_model(s);
      w = 5 + int'(s % 31'd46);
      exp_q.push_back(8'(w));
    end
    exp_cap = (exp_total * 40) / 100;
  endtask

  // Compares the whole default instance against the model queue.
  task automatic check_instance(input string run);
    logic [7:0] e;
    int bad_v, bad_w;
    bad_v = 0;
    bad_w = 0;
    for (int i = 0; i < L; i++) begin
      e = exp_q.pop_front();
      if (item_values[i*8 +: 8] !== e) bad_v++;
    end
    for (int i = 0; i < L; i++) begin
      e = exp_q.pop_front();
      if (item_weights[i*8 +: 8] !== e) bad_w++;
    end
    check({run, " value bytes mismatching model"}, bad_v, 0);
    check({run, " weight bytes mismatching model"}, bad_w, 0);
    check({run, " total_weight"}, {16'd0, total_weight}, exp_total);
    check({run, " capacity"}, {16'd0, capacity}, exp_cap);
  endtask

  // Driver: raise start, hold it for hold_cycles, then wait (bounded) for
  // done. lat counts posedges after the accept edge until done is seen;
  // done_after is done sampled just after the accept edge.
  task automatic start_and_wait(input bit sel, input int hold_cycles, input int budget,
                                output int lat, output logic done_after);
    @(negedge clk);
    if (sel) start1 = 1'b1; else start = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    done_after = sel ? done1 : done;
    if (hold_cycles <= 1) begin
      start = 1'b0;
      start1 = 1'b0;
    end
    while (!(sel ? done1 : done) && lat < budget) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat >= hold_cycles - 1) begin
        start = 1'b0;
        start1 = 1'b0;
      end
    end
    start = 1'b0;
    start1 = 1'b0;
  endtask

  int            lat;
  logic          dafter;
  logic [NB-1:0] r1_values, r1_weights;
  int            out_of_range;

  initial begin
    rst    = 1'b0;
    rst1   = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state (still in reset)
    check("reset busy", {31'd0, busy}, 0);
    check("reset done", {31'd0, done}, 0);
    check("reset values nonzero", {31'd0, |item_values}, 0);
    check("reset weights nonzero", {31'd0, |item_weights}, 0);
    check("reset total_weight", {16'd0, total_weight}, 0);
    check("reset capacity", {16'd0, capacity}, 0);
    check("reset fsm_state", {29'd0, fsm_state}, 0);

    rst  = 1'b1;
    rst1 = 1'b1;
    repeat (2) @(posedge clk);

    // Run 1: single start pulse
    load_model();
    start_and_wait(1'b0, 1, 9000, lat, dafter);
    check("run1 latency", lat, 8217);
    check("run1 busy at done", {31'd0, busy}, 0);
    check("run1 value[0]", {24'd0, item_values[7:0]}, 63);
    check("run1 weight[0]", {24'd0, item_weights[7:0]}, 29);
    check_instance("run1");
    out_of_range = 0;
    for (int i = 0; i < L; i++) begin
      if (item_values[i*8 +: 8] < 8'd10 || item_values[i*8 +: 8] > 8'd100) out_of_range++;
      if (item_weights[i*8 +: 8] < 8'd5 || item_weights[i*8 +: 8] > 8'd50) out_of_range++;
    end
    check("run1 bytes out of range", out_of_range, 0);
    r1_values  = item_values;
    r1_weights = item_weights;

    // Run 2: start accepted from DONE, then held high for 100 cycles
    load_model();
    start_and_wait(1'b0, 100, 9000, lat, dafter);
    check("run2 done drops on accept", {31'd0, dafter}, 0);
    check("run2 latency with held start", lat, 8217);
    check("run2 values identical to run1", {31'd0, item_values === r1_values}, 1);
    check("run2 weights identical to run1", {31'd0, item_weights === r1_weights}, 1);
    check_instance("run2");

    // Reset 3000 cycles into a run
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2999) @(posedge clk);
    #2;
    check("pre-abort busy", {31'd0, busy}, 1);
    rst = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 0);
    check("abort done", {31'd0, done}, 0);
    check("abort values nonzero", {31'd0, |item_values}, 0);
    check("abort weights nonzero", {31'd0, |item_weights}, 0);
    check("abort total_weight", {16'd0, total_weight}, 0);
    check("abort capacity", {16'd0, capacity}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    load_model();
    start_and_wait(1'b0, 1, 9000, lat, dafter);
    check("post-abort latency", lat, 8217);
    check("post-abort value[0]", {24'd0, item_values[7:0]}, 63);
    check_instance("post-abort");

    // One item, 100 % capacity
    start_and_wait(1'b1, 1, 200, lat, dafter);
    check("L1 latency", lat, 89);
    check("L1 value", {24'd0, item_values1}, 63);
    check("L1 weight", {24'd0, item_weights1}, 29);
    check("L1 total_weight", {16'd0, total_weight1}, 29);
    check("L1 capacity", {16'd0, capacity1}, 29);
    check("L1 busy at done", {31'd0, busy1}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
